// File: rtl/l2_bank_arbiter_if.sv
// Requester-side TCDM bundle for l2_bank_arbiter: flattened per-master request
// fields plus grant / response. The arbiter uses the slave modport; the
// masters (or a testbench) use the master modport.
interface l2_bank_arbiter_if #(
    parameter int unsigned NB_MASTERS = 2
);
    logic [NB_MASTERS-1:0]    req_i;
    logic [NB_MASTERS*32-1:0] add_i;
    logic [NB_MASTERS-1:0]    wen_i;
    logic [NB_MASTERS*32-1:0] wdata_i;
    logic [NB_MASTERS*4-1:0]  be_i;
    logic [NB_MASTERS-1:0]    gnt_o;
    logic [NB_MASTERS-1:0]    r_valid_o;
    logic [31:0]              r_rdata_o;

    modport slave (
        input  req_i, add_i, wen_i, wdata_i, be_i,
        output gnt_o, r_valid_o, r_rdata_o
    );

    modport master (
        output req_i, add_i, wen_i, wdata_i, be_i,
        input  gnt_o, r_valid_o, r_rdata_o
    );
endinterface

// File: rtl/l2_bank_arbiter.sv
// Round-robin arbiter sharing one single-ported L2 SRAM bank between
// NB_MASTERS requesters. Fixed 1-cycle response latency for reads and writes.
// After reset the bank is optionally zero-filled, one word per cycle, before
// any request is granted.
module l2_bank_arbiter #(
    parameter int unsigned NB_MASTERS     = 2,
    parameter int unsigned ADDR_WIDTH     = 13,
    parameter logic [31:0] BASE_ADDR      = 32'h1C000000,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    l2_bank_arbiter_if.slave      bus,
    output logic                  mem_csn_o,
    output logic                  mem_wen_o,
    output logic [3:0]            mem_be_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    input  logic [31:0]           mem_rdata_i,
    output logic                  init_done_o
);

    localparam int unsigned PTR_W = (NB_MASTERS > 1) ? $clog2(NB_MASTERS) : 1;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_clr_cnt;
    logic [PTR_W-1:0]        r_rr_ptr;
    logic [NB_MASTERS-1:0]   r_r_valid;
    logic                    r_init_done;

    logic                    w_found;
    logic [PTR_W-1:0]        w_idx;
    logic [31:0]             w_sel_add;
    logic                    w_sel_wen;
    logic [3:0]              w_sel_be;
    logic [31:0]             w_sel_wdata;
    logic [NB_MASTERS-1:0]   w_gnt;

    // Round-robin search: first requester at or after r_rr_ptr, wrapping upward.
    always_comb begin
        int unsigned v_cand;
        v_cand      = 0;
        w_found     = 1'b0;
        w_idx       = '0;
        w_sel_add   = '0;
        w_sel_wen   = 1'b1;
        w_sel_be    = '0;
        w_sel_wdata = '0;
        for (int unsigned i = 0; i < NB_MASTERS; i++) begin
            v_cand = (32'(r_rr_ptr) + i) % NB_MASTERS;
            if (!w_found && bus.req_i[v_cand[PTR_W-1:0]]) begin
                w_found     = 1'b1;
                w_idx       = v_cand[PTR_W-1:0];
                w_sel_add   = bus.add_i[32*v_cand +: 32];
                w_sel_wen   = bus.wen_i[v_cand[PTR_W-1:0]];
                w_sel_be    = bus.be_i[4*v_cand +: 4];
                w_sel_wdata = bus.wdata_i[32*v_cand +: 32];
            end
        end
    end

    // Bank drive: zero-fill writes while clearing, granted master's access in RUN.
    // Nothing reaches the bank while reset is held.
    always_comb begin
        mem_csn_o   = 1'b1;
        mem_wen_o   = 1'b1;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        w_gnt       = '0;
        if (r_state == ST_CLEAR) begin
            mem_csn_o  = ~rst_ni;
            mem_wen_o  = 1'b0;
            mem_be_o   = '1;
            mem_addr_o = r_clr_cnt;
        end else if (w_found && rst_ni) begin
            w_gnt[w_idx] = 1'b1;
            mem_csn_o    = 1'b0;
            mem_wen_o    = w_sel_wen;
            mem_be_o     = w_sel_be;
            mem_wdata_o  = w_sel_wdata;
            mem_addr_o   = ADDR_WIDTH'((w_sel_add - BASE_ADDR) >> 2);
        end
    end

    // FSM: clear counter, round-robin pointer, registered response and init flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            r_clr_cnt   <= '0;
            r_rr_ptr    <= '0;
            r_r_valid   <= '0;
            r_init_done <= (CLEAR_ON_RESET == 0);
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_r_valid <= '0;
                    r_clr_cnt <= r_clr_cnt + ADDR_WIDTH'(1);
                    if (r_clr_cnt == '1) begin
                        r_state     <= ST_RUN;
                        r_init_done <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_init_done <= 1'b1;
                    r_r_valid   <= w_gnt;
                    if (w_found) begin
                        r_rr_ptr <= (w_idx == PTR_W'(NB_MASTERS - 1)) ? '0 : w_idx + PTR_W'(1);
                    end
                end
                default: r_state <= ST_CLEAR;
            endcase
        end
    end

    assign bus.gnt_o     = w_gnt;
    assign bus.r_valid_o = r_r_valid;
    assign bus.r_rdata_o = mem_rdata_i;
    assign init_done_o   = r_init_done;

endmodule
